// File: rtl/fpu_pkg.sv
// Shared FPU types: operand class encodings (used by rounding/packing too)
// and the pre-normalization FSM state.
package fpu_pkg;

  localparam int CLASS_W = 3;

  typedef enum logic [CLASS_W-1:0] {
    ZERO      = 3'd0,
    SUBNORMAL = 3'd1,
    NORMAL    = 3'd2,
    INF       = 3'd3,
    QNAN      = 3'd4,
    SNAN      = 3'd5
  } fp_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } prenorm_state_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier: raw exponent/fraction fields in, class out.
// Also used by the packer's special-case path.
module fpu_classify
  import fpu_pkg::*;
#(
  parameter int EXPONENT_WIDTH    = 11,
  parameter int SIGNIFICAND_WIDTH = 52
) (
  input  logic [EXPONENT_WIDTH-1:0]    i_exponent,
  input  logic [SIGNIFICAND_WIDTH-1:0] i_fraction,
  output fp_class_t                    o_class
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_frac_zero;

  assign w_exp_zero  = (i_exponent == '0);
  assign w_exp_ones  = (i_exponent == '1);
  assign w_frac_zero = (i_fraction == '0);

  // NOTE: assigning a default before any branch keeps combinational logic latch-free.
  always_comb begin
    o_class = NORMAL;
    if (w_exp_zero) begin
      o_class = w_frac_zero ? ZERO : SUBNORMAL;
    end else if (w_exp_ones) begin
      if (w_frac_zero)                            o_class = INF;
      else if (i_fraction[SIGNIFICAND_WIDTH-1])   o_class = QNAN;
      else                                        o_class = SNAN;
    end
  end

endmodule

// File: rtl/fpu_prenorm.sv
// Operand pre-normalization: inserts the hidden bit and left-normalizes
// subnormals one bit per cycle, producing a widened signed biased exponent.
module fpu_prenorm
  import fpu_pkg::*;
#(
  parameter int EXPONENT_WIDTH    = 11,
  parameter int SIGNIFICAND_WIDTH = 52
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [EXPONENT_WIDTH-1:0]    in_exponent,
  input  logic [SIGNIFICAND_WIDTH-1:0] in_fraction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sign,
  output logic [EXPONENT_WIDTH:0]      out_exponent,
  output logic [SIGNIFICAND_WIDTH:0]   out_mantissa,
  output fp_class_t                    out_class
);

  localparam int EXP_W  = EXPONENT_WIDTH + 1;
  localparam int MANT_W = SIGNIFICAND_WIDTH + 1;

  prenorm_state_t r_state, w_state_next;
  fp_class_t      w_in_class;
  logic           w_accept;
  logic           w_shift;
  logic [EXP_W-1:0]  w_load_exp;
  logic [MANT_W-1:0] w_load_mant;

  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  fp_class_t         r_class;

  fpu_classify #(
    .EXPONENT_WIDTH   (EXPONENT_WIDTH),
    .SIGNIFICAND_WIDTH(SIGNIFICAND_WIDTH)
  ) u_classify (
    .i_exponent(in_exponent),
    .i_fraction(in_fraction),
    .o_class   (w_in_class)
  );

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (w_in_class == SUBNORMAL) ? NORM : DONE;
      end
      NORM: begin
        w_shift = 1'b1;
        // The bit below the MSB lands in the MSB on this shift.
        if (r_mant[MANT_W-2]) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_state_next = (w_in_class == SUBNORMAL) ? NORM : DONE;
          else          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load_mant = {1'b0, in_fraction};
    w_load_exp  = {1'b0, {EXPONENT_WIDTH{1'b1}}};
    case (w_in_class)
      NORMAL: begin
        w_load_mant = {1'b1, in_fraction};
        w_load_exp  = {1'b0, in_exponent};
      end
      ZERO: begin
        w_load_mant = '0;
        w_load_exp  = '0;
      end
      SUBNORMAL: w_load_exp = EXP_W'(1);
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_class <= ZERO;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_sign  <= in_sign;
        r_class <= w_in_class;
        r_exp   <= w_load_exp;
        r_mant  <= w_load_mant;
      end else if (w_shift) begin
        r_mant <= {r_mant[MANT_W-2:0], 1'b0};
        r_exp  <= r_exp - 1'b1;
      end
    end
  end

  assign out_sign     = r_sign;
  assign out_exponent = r_exp;
  assign out_mantissa = r_mant;
  assign out_class    = r_class;

endmodule

// File: tb/tb_fpu_prenorm.sv
// Self-checking bench for fpu_prenorm: scoreboard of modelled results,
// plus latency, backpressure, streaming and mid-operation reset checks.
module tb_fpu_prenorm;
  import fpu_pkg::*;

  localparam int EW = 11;
  localparam int SW = 52;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exponent;
  logic [SW-1:0] in_fraction;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW:0]   out_exponent;
  logic [SW:0]   out_mantissa;
  fp_class_t     out_class;

  fpu_prenorm #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_fraction (in_fraction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exponent(out_exponent),
    .out_mantissa(out_mantissa),
    .out_class   (out_class)
  );

  typedef struct {
    logic        sign;
    logic [EW:0] exp;
    logic [SW:0] mant;
    logic [2:0]  cls;
  } result_t;

  result_t q[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic result_t model(input logic s, input logic [EW-1:0] e, input logic [SW-1:0] f);
    result_t r;
    int z;
    r.sign = s;
    if (e == 0 && f == 0) begin
      r.cls = 3'd0; r.exp = '0; r.mant = '0;
    end else if (e == 0) begin
      z = 0;
      for (int i = SW - 1; i >= 0 && !f[i]; i--) z++;
      r.cls  = 3'd1;
      r.mant = {1'b0, f} << (z + 1);
      r.exp  = (EW+1)'(-z);
    end else if (e == {EW{1'b1}}) begin
      r.cls  = (f == 0) ? 3'd3 : (f[SW-1] ? 3'd4 : 3'd5);
      r.mant = {1'b0, f};
      r.exp  = {1'b0, {EW{1'b1}}};
    end else begin
      r.cls = 3'd2; r.mant = {1'b1, f}; r.exp = {1'b0, e};
    end
    return r;
  endfunction

  // Scoreboard consumer: every handshake-completed result is compared in order.
  always @(negedge clk) begin
    result_t r;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 64'(1), 64'(0));
      end else begin
        r = q.pop_front();
        check("sb_sign",  64'(out_sign),     64'(r.sign));
        check("sb_exp",   64'(out_exponent), 64'(r.exp));
        check("sb_mant",  64'(out_mantissa), 64'(r.mant));
        check("sb_class", 64'(out_class),    64'(r.cls));
      end
    end
  end

  task automatic drive(input logic s, input logic [EW-1:0] e, input logic [SW-1:0] f);
    in_valid = 1'b1; in_sign = s; in_exponent = e; in_fraction = f;
  endtask

  // Single operand with out_ready=1; counts negedges until out_valid.
  task automatic run_one(input logic s, input logic [EW-1:0] e, input logic [SW-1:0] f,
                         input int lat, input string tag);
    logic acc;
    int n;
    drive(s, e, f);
    out_ready = 1'b1;
    @(negedge clk);
    acc = in_valid && in_ready;
    check({tag, "_accept"}, 64'(acc), 64'(1));
    @(posedge clk);
    if (acc) q.push_back(model(s, e, f));
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      check({tag, "_norm_ready"}, 64'(in_ready), 64'(0));
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  logic [EW-1:0] st_e[4] = '{11'h3FF, 11'h400, 11'h401, 11'h3FE};
  logic [SW-1:0] st_f[4] = '{52'h0, 52'h8000000000000, 52'h123456789ABCD, 52'hFFFFFFFFFFFFF};

  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_fraction = '0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid),    64'(0));
    check("rst_sign",  64'(out_sign),     64'(0));
    check("rst_exp",   64'(out_exponent), 64'(0));
    check("rst_mant",  64'(out_mantissa), 64'(0));
    check("rst_class", 64'(out_class),    64'(ZERO));
    #11 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    run_one(1'b0, 11'h3FF, 52'h0, 1, "one");
    run_one(1'b0, 11'h000, 52'h1, 53, "min_sub");
    run_one(1'b1, 11'h000, 52'h8000000000000, 2, "max_sub");
    run_one(1'b0, 11'h000, 52'h0000012345678, 25, "mid_sub");
    run_one(1'b0, 11'h7FF, 52'h0, 1, "inf");
    run_one(1'b1, 11'h7FF, 52'h8000000000000, 1, "qnan");
    run_one(1'b0, 11'h7FF, 52'h1, 1, "snan");
    run_one(1'b0, 11'h000, 52'h0, 1, "zero");

    // Backpressure: hold one result, a new operand waiting at the input.
    out_ready = 1'b0;
    drive(1'b1, 11'h3FF, 52'hABCDE);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) q.push_back(model(1'b1, 11'h3FF, 52'hABCDE));
    #1 drive(1'b0, st_e[0], st_f[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_ready", 64'(in_ready),  64'(0));
      if (q.size() > 0) begin
        check("bp_exp",  64'(out_exponent), 64'(q[0].exp));
        check("bp_mant", 64'(out_mantissa), 64'(q[0].mant));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, st_e[k], st_f[k]);
      @(negedge clk);
      acc = in_valid && in_ready;
      check("stream_ready", 64'(acc),       64'(1));
      check("stream_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      if (acc) q.push_back(model(1'b0, st_e[k], st_f[k]));
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_idle", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // Reset mid-normalization abandons the operand.
    drive(1'b0, 11'h000, 52'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid", 64'(out_valid),    64'(0));
    check("mid_rst_exp",   64'(out_exponent), 64'(0));
    check("mid_rst_mant",  64'(out_mantissa), 64'(0));
    check("mid_rst_class", 64'(out_class),    64'(ZERO));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_one(1'b0, 11'h400, 52'h0, 1, "two");

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
